// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and stall sequencer for the 5-stage RV32 core.
//
// Each cycle this block decides whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// advance, hold or load a bubble. It arbitrates three hazard sources, listed
// here from highest to lowest priority:
//   1. Data-memory wait.
//   2. Branch/jump redirect from EX.
//   3. Load-use.
// A bounded memory-wait FSM aborts an access that has stalled for
// MEM_TIMEOUT cycles.
//
// Parameter:
//   MEM_TIMEOUT   maximum consecutive stalled cycles per access (2..255).
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   memread_ex, rd_ex         EX holds a load and its destination register
//   rs1_id, rs2_id            ID source registers
//   uses_rs1_id, uses_rs2_id  ID really reads rs1 / rs2
//   redirect_ex               EX resolved a taken branch / JAL / JALR
//   dmem_req, dmem_ready      MEM access in flight / completes this cycle
//   pc_write, ifid_write      PC and IF/ID capture enables
//   ifid_flush, idex_flush    bubble IF/ID, ID/EX
//   idex_hold, exmem_hold     hold ID/EX, EX/MEM
//   memwb_flush               bubble MEM/WB
//   mem_timeout               sticky flag: an access was aborted
//   dbg_state, dbg_wcnt       FSM state (0=RUN, 1=MEMWAIT, 2=ABORT) and wait count
//
// Optional feature (macro HAZARD_STATS_EN): adds two 32-bit outputs.
//   stall_count  counts cycles with pc_write low.
//   flush_count  counts cycles in which a redirect is applied.
//
// Handshake: this block has no valid/ready pairs. Every control output is
// combinational from the FSM state, the wait counter and the current inputs,
// so the output takes effect in the same cycle.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        uses_rs1_id,
  input  logic        uses_rs2_id,
  input  logic        redirect_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_wcnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_ABORT   = 2'd2
  } state_t;

  // Wait count at which a still-unready access gets aborted.
  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       timeout_q, timeout_d;
  logic       mstall;
  logic       load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wcnt_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    timeout_d   = timeout_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    memwb_flush = 1'b0;

    // The ABORT cycle releases the stall even while the access is still pending.
    mstall   = dmem_req & ~dmem_ready & (state_q != ST_ABORT);
    load_use = memread_ex & (rd_ex != 5'd0) &
               ((uses_rs1_id & (rs1_id == rd_ex)) |
                (uses_rs2_id & (rs2_id == rd_ex)));

    // Output arbitration. During a memory stall EX is held, so a pending
    // redirect is simply seen again on the first released cycle.
    if (mstall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
    end else if (redirect_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end

    // The aborted access must never reach write-back.
    if (state_q == ST_ABORT) begin
      memwb_flush = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        if (mstall) begin
          state_d = ST_MEMWAIT;
          wcnt_d  = 8'd1;
        end
      end
      ST_MEMWAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d   = ST_ABORT;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ST_ABORT: begin
        state_d = ST_RUN;
        wcnt_d  = 8'd0;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = 8'd0;
      end
    endcase

    // While in reset every control is quiet, so no stage register moves.
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      idex_hold   = 1'b0;
      exmem_hold  = 1'b0;
      memwb_flush = 1'b0;
    end
  end

  assign mem_timeout = timeout_q;
  assign dbg_state   = state_q;
  assign dbg_wcnt    = wcnt_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (!pc_write) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (redirect_ex && !mstall) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl, built with MEM_TIMEOUT = 4.
// It has three parts:
//   - Constant vectors for the single-cycle arbitration cases.
//   - Hand-written multi-cycle sequences: memory wait, timeout, redirect
//     during a stall, and reset in MEMWAIT.
//   - Randomized cycles checked against a behavioural model. The model tracks
//     how long the current access has waited, whether the abort cycle is due,
//     and the sticky timeout flag.
// Output vector bit order, MSB to LSB:
//   pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold,
//   memwb_flush, mem_timeout
module tb_hazard_ctrl;
  localparam int T = 4;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam logic [7:0] O_NORM  = 8'b1100_0000;
  localparam logic [7:0] O_STALL = 8'b0000_1110;
  localparam logic [7:0] O_REDIR = 8'b1111_0000;
  localparam logic [7:0] O_LU    = 8'b0001_0000;

  logic clk = 1'b0;
  logic rst, memread_ex, uses_rs1_id, uses_rs2_id, redirect_ex, dmem_req, dmem_ready;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic pc_write, ifid_write, ifid_flush, idex_flush, idex_hold, exmem_hold;
  logic memwb_flush, mem_timeout;
  logic [1:0] dbg_state;
  logic [7:0] dbg_wcnt;
  logic [7:0] outs;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  assign outs = {pc_write, ifid_write, ifid_flush, idex_flush,
                 idex_hold, exmem_hold, memwb_flush, mem_timeout};

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .memread_ex(memread_ex), .rd_ex(rd_ex),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .redirect_ex(redirect_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .idex_hold(idex_hold), .exmem_hold(exmem_hold),
    .memwb_flush(memwb_flush), .mem_timeout(mem_timeout),
    .dbg_state(dbg_state), .dbg_wcnt(dbg_wcnt)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
    $fatal(1, "watchdog");
  end

  // Scoreboard and model state
  int total = 0;
  int bad   = 0;
  int          m_waited;  // cycles the current access has waited so far (0 = idle)
  bit          m_abort;   // the coming cycle is the abort cycle
  bit          m_to;      // sticky timeout flag
  logic [31:0] m_stalls, m_flushes;
  logic [7:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_eval();
    logic [7:0] o;
    bit st, lu;
    if (rst) return 8'h00;
    st = dmem_req && !dmem_ready && !m_abort;
    lu = memread_ex && rd_ex != 0 &&
         ((uses_rs1_id && rs1_id == rd_ex) || (uses_rs2_id && rs2_id == rd_ex));
    if (st)               o = O_STALL;
    else if (redirect_ex) o = O_REDIR;
    else if (lu)          o = O_LU;
    else                  o = O_NORM;
    if (m_abort) o[1] = 1'b1;
    o[0] = m_to;
    return o;
  endfunction

  // Advance the model across the coming rising edge.
  task automatic model_advance(input logic [7:0] o);
    bit st;
    st = dmem_req && !dmem_ready && !m_abort;
    if (rst) begin
      m_waited = 0; m_abort = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!o[7]) m_stalls++;
      if (redirect_ex && !st) m_flushes++;
      if (m_abort) begin
        m_abort = 0; m_waited = 0;
      end else if (m_waited == 0) begin
        if (st) m_waited = 1;
      end else if (dmem_ready) begin
        m_waited = 0;
      end else if (m_waited == T - 1) begin
        m_abort = 1; m_to = 1; m_waited = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  // Driver: apply one cycle of inputs at negedge, compare against the model
  // 1 ns later, then advance the model.
  task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                      input logic u2, input logic rdr, input logic req, input logic rdy);
    logic [7:0] e;
    @(negedge clk);
    rst = r; memread_ex = mr; rd_ex = rd; rs1_id = r1; rs2_id = r2;
    uses_rs1_id = u1; uses_rs2_id = u2; redirect_ex = rdr;
    dmem_req = req; dmem_ready = rdy;
    #1;
    e = model_eval();
    exp_q.push_back(e);
    check("model", {24'd0, outs}, {24'd0, exp_q.pop_front()});
    model_advance(e);
  endtask

  task automatic mem(input logic r, input logic rdr, input logic req, input logic rdy);
    step(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, rdr, req, rdy);
  endtask

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] rd, r1, r2;
    logic       u1, u2, rdr, req, rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    rst = 1; memread_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0;
    uses_rs1_id = 0; uses_rs2_id = 0; redirect_ex = 0; dmem_req = 0; dmem_ready = 0;
    m_waited = 0; m_abort = 0; m_to = 0; m_stalls = 0; m_flushes = 0;

    vt[0] = '{"normal",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_NORM};
    vt[1] = '{"lu_rs1",        1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, O_LU};
    vt[2] = '{"lu_rd0",        1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, O_NORM};
    vt[3] = '{"lu_rs2",        1, 5'd9, 5'd1, 5'd9, 0, 1, 0, 0, 0, O_LU};
    vt[4] = '{"lu_rs2_unused", 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0, 0, O_NORM};
    vt[5] = '{"no_load",       0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, O_NORM};
    vt[6] = '{"redir_and_lu",  1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, O_REDIR};
    vt[7] = '{"redir_only",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, O_REDIR};
    vt[8] = '{"single_access", 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, O_NORM};
    vt[9] = '{"lu_rs1_unused", 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 0, O_NORM};

    // Reset state
    mem(1, 0, 0, 0);
    check("reset_outs", {24'd0, outs}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("reset_wcnt", {24'd0, dbg_wcnt}, 32'd0);

    // Constant vectors
    for (int i = 0; i < 10; i++) begin
      step(0, vt[i].mr, vt[i].rd, vt[i].r1, vt[i].r2, vt[i].u1, vt[i].u2,
           vt[i].rdr, vt[i].req, vt[i].rdy);
      check(vt[i].name, {24'd0, outs}, {24'd0, vt[i].exp});
    end

    // Three-cycle memory wait, then ready
    for (int i = 0; i < 3; i++) begin
      mem(0, 0, 1, 0);
      check("wait_stall", {24'd0, outs}, {24'd0, O_STALL});
    end
    mem(0, 0, 1, 1);
    check("wait_release", {24'd0, outs}, {24'd0, O_NORM});
    @(posedge clk); #1;
    check("wait_back_run", {30'd0, dbg_state}, {30'd0, S_RUN});

    // Timeout: T stalled cycles, then the ABORT cycle
    for (int i = 0; i < T; i++) begin
      mem(0, 0, 1, 0);
      check("to_stall", {24'd0, outs}, {24'd0, O_STALL});
    end
    mem(0, 0, 1, 0);
    check("to_abort_outs", {24'd0, outs}, {24'd0, O_NORM | 8'b0000_0011});
    check("to_abort_state", {30'd0, dbg_state}, {30'd0, S_ABORT});
    mem(0, 0, 0, 0);
    check("to_sticky", {24'd0, outs}, {24'd0, O_NORM | 8'b0000_0001});
    mem(1, 0, 0, 0);
    check("to_reset_clears", {24'd0, outs}, 32'd0);

    // Redirect held through a stall acts on the release cycle
    for (int i = 0; i < 2; i++) begin
      mem(0, 1, 1, 0);
      check("redir_in_stall", {24'd0, outs}, {24'd0, O_STALL});
    end
    mem(0, 1, 1, 1);
    check("redir_on_release", {24'd0, outs}, {24'd0, O_REDIR});

    // Reset asserted in MEMWAIT at wcnt=2
    mem(0, 0, 0, 0);
    mem(0, 0, 1, 0);
    mem(0, 0, 1, 0);
    @(posedge clk); #1;
    check("pre_rst_wcnt", {24'd0, dbg_wcnt}, 32'd2);
    mem(1, 0, 1, 0);
    check("rst_mid_outs", {24'd0, outs}, 32'd0);
    check("rst_mid_state", {30'd0, dbg_state}, {30'd0, S_RUN});
    check("rst_mid_wcnt", {24'd0, dbg_wcnt}, 32'd0);
    mem(0, 0, 1, 0);
    check("rst_restall", {24'd0, outs}, {24'd0, O_STALL});
    @(posedge clk); #1;
    check("rst_restart_wcnt", {24'd0, dbg_wcnt}, 32'd1);

    // Randomized cycles against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end

`ifdef HAZARD_STATS_EN
    @(posedge clk); #1;
    check("stall_count", stall_count, m_stalls);
    check("flush_count", flush_count, m_flushes);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
